// File: rtl/ncc_pkg.sv
// Shared types and constants for the NCC search scheduler and its best-score tracker.
package ncc_pkg;

    localparam int NCC_GRID_DIM   = 16;
    localparam int NCC_COL_GROUPS = 4;
    localparam int NCC_SCORE_W    = 32;

    localparam logic [NCC_SCORE_W-1:0] NCC_SCORE_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DESC   = 3'd1,
        ST_WREQ   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CMP    = 3'd4,
        ST_DONE   = 3'd5
    } sched_state_t;

endpackage

// File: rtl/ncc_best_tracker.sv
// Holds the best signed correlation score of a search and the window position that produced it.
module ncc_best_tracker
    import ncc_pkg::*;
#(
    parameter int COORD_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   first,
    input  logic                   valid,
    input  logic [NCC_SCORE_W-1:0] score,
    input  logic [COORD_W-1:0]     x,
    input  logic [COORD_W-1:0]     y,
    output logic [NCC_SCORE_W-1:0] best_score,
    output logic [COORD_W-1:0]     best_x,
    output logic [COORD_W-1:0]     best_y
);

    logic [NCC_SCORE_W-1:0] best_score_q, best_score_d;
    logic [COORD_W-1:0]     best_x_q, best_x_d;
    logic [COORD_W-1:0]     best_y_q, best_y_d;
    logic                   better;

    // Strictly greater: on a tie the earlier raster position is kept.
    assign better = $signed(score) > $signed(best_score_q);

    always_comb begin
        best_score_d = best_score_q;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
        if (clear) begin
            best_score_d = NCC_SCORE_MIN;
            best_x_d     = '0;
            best_y_d     = '0;
        end else if (valid && (first || better)) begin
            best_score_d = score;
            best_x_d     = x;
            best_y_d     = y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_score_q <= NCC_SCORE_MIN;
            best_x_q     <= '0;
            best_y_q     <= '0;
        end else begin
            best_score_q <= best_score_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
        end
    end

    assign best_score = best_score_q;
    assign best_x     = best_x_q;
    assign best_y     = best_y_q;

endmodule

// File: rtl/ncc_search_scheduler.sv
// Sequences the NCC PE grid: loads one descriptor, then raster-scans all window positions
// and reports the best signed score. Handshakes: a transfer happens on a rising edge where
// both valid and ready (req) are high; the grid strobe for it is asserted in that same cycle.
module ncc_search_scheduler
    import ncc_pkg::*;
#(
    parameter int DESC_WORDS    = 64,
    parameter int SEARCH_W      = 32,
    parameter int SEARCH_H      = 32,
    parameter int COORD_W       = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [31:0]            desc_data,
    output logic [31:0]            grid_desc_data,
    output logic                   grid_desc_load,
    output logic [3:0]             grid_desc_row,
    output logic [1:0]             grid_desc_col,
    output logic                   win_req,
    output logic [COORD_W-1:0]     win_x,
    output logic [COORD_W-1:0]     win_y,
    input  logic                   win_valid,
    output logic                   grid_win_load,
    input  logic [NCC_SCORE_W-1:0] score_in,
    output logic                   busy,
    output logic                   done,
    output logic [NCC_SCORE_W-1:0] best_score,
    output logic [COORD_W-1:0]     best_x,
    output logic [COORD_W-1:0]     best_y,
    output sched_state_t           dbg_state
);

    localparam int DESC_CNT_W = $clog2(DESC_WORDS);
    localparam int COL_W      = $clog2(NCC_COL_GROUPS);
    localparam int SETTLE_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [DESC_CNT_W-1:0] DESC_LAST   = DESC_CNT_W'(DESC_WORDS - 1);
    localparam logic [COORD_W-1:0]    X_LAST      = COORD_W'(SEARCH_W - 1);
    localparam logic [COORD_W-1:0]    Y_LAST      = COORD_W'(SEARCH_H - 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

    sched_state_t          state_q, state_d;
    logic [DESC_CNT_W-1:0] desc_cnt_q, desc_cnt_d;
    logic [COORD_W-1:0]    x_q, x_d;
    logic [COORD_W-1:0]    y_q, y_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  first_q, first_d;

    logic trk_clear;
    logic trk_valid;

    always_comb begin
        state_d        = state_q;
        desc_cnt_d     = desc_cnt_q;
        x_d            = x_q;
        y_d            = y_q;
        settle_d       = settle_q;
        first_d        = first_q;
        desc_ready     = 1'b0;
        grid_desc_load = 1'b0;
        win_req        = 1'b0;
        grid_win_load  = 1'b0;
        done           = 1'b0;
        trk_clear      = 1'b0;
        trk_valid      = 1'b0;

        // Abort outranks every transition and discards the partial result.
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            desc_cnt_d = '0;
            x_d        = '0;
            y_d        = '0;
            settle_d   = '0;
            first_d    = 1'b0;
            trk_clear  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d    = ST_DESC;
                        desc_cnt_d = '0;
                        x_d        = '0;
                        y_d        = '0;
                        first_d    = 1'b1;
                        trk_clear  = 1'b1;
                    end
                end
                ST_DESC: begin
                    desc_ready     = 1'b1;
                    grid_desc_load = desc_valid;
                    if (desc_valid) begin
                        if (desc_cnt_q == DESC_LAST) begin
                            desc_cnt_d = '0;
                            state_d    = ST_WREQ;
                        end else begin
                            desc_cnt_d = desc_cnt_q + 1'b1;
                        end
                    end
                end
                ST_WREQ: begin
                    win_req = 1'b1;
                    if (win_valid) begin
                        grid_win_load = 1'b1;
                        settle_d      = SETTLE_INIT;
                        state_d       = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = ST_CMP;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
                ST_CMP: begin
                    trk_valid = 1'b1;
                    first_d   = 1'b0;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            y_d     = y_q + 1'b1;
                            state_d = ST_WREQ;
                        end
                    end else begin
                        x_d     = x_q + 1'b1;
                        state_d = ST_WREQ;
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            desc_cnt_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            settle_q   <= '0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            desc_cnt_q <= desc_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            settle_q   <= settle_d;
            first_q    <= first_d;
        end
    end

    ncc_best_tracker #(
        .COORD_W (COORD_W)
    ) u_best (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (trk_clear),
        .first      (first_q),
        .valid      (trk_valid),
        .score      (score_in),
        .x          (x_q),
        .y          (y_q),
        .best_score (best_score),
        .best_x     (best_x),
        .best_y     (best_y)
    );

    // Descriptor slot: low bits pick the column group, the rest the PE row.
    assign grid_desc_row  = desc_cnt_q[DESC_CNT_W-1:COL_W];
    assign grid_desc_col  = desc_cnt_q[COL_W-1:0];
    assign grid_desc_data = (state_q == ST_DESC) ? desc_data : '0;
    assign win_x          = x_q;
    assign win_y          = y_q;
    assign busy           = (state_q != ST_IDLE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ncc_search_scheduler.sv
// Scoreboard bench for ncc_search_scheduler on a 4x4 search grid with directed score tables.
module tb_ncc_search_scheduler;
    import ncc_pkg::*;

    localparam int SW   = 4;
    localparam int SH   = 4;
    localparam int CW   = 8;
    localparam int NWIN = SW * SH;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          desc_valid;
    logic          desc_ready;
    logic [31:0]   desc_data;
    logic [31:0]   grid_desc_data;
    logic          grid_desc_load;
    logic [3:0]    grid_desc_row;
    logic [1:0]    grid_desc_col;
    logic          win_req;
    logic [CW-1:0] win_x;
    logic [CW-1:0] win_y;
    logic          win_valid;
    logic          grid_win_load;
    logic [31:0]   score_in;
    logic          busy;
    logic          done;
    logic [31:0]   best_score;
    logic [CW-1:0] best_x;
    logic [CW-1:0] best_y;
    sched_state_t  dbg_state;

    ncc_search_scheduler #(
        .DESC_WORDS    (64),
        .SEARCH_W      (SW),
        .SEARCH_H      (SH),
        .COORD_W       (CW),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_data      (desc_data),
        .grid_desc_data (grid_desc_data),
        .grid_desc_load (grid_desc_load),
        .grid_desc_row  (grid_desc_row),
        .grid_desc_col  (grid_desc_col),
        .win_req        (win_req),
        .win_x          (win_x),
        .win_y          (win_y),
        .win_valid      (win_valid),
        .grid_win_load  (grid_win_load),
        .score_in       (score_in),
        .busy           (busy),
        .done           (done),
        .best_score     (best_score),
        .best_x         (best_x),
        .best_y         (best_y),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [37:0] desc_exp_q[$];   // {row, col, data}
    logic [15:0] win_exp_q[$];    // {x, y}
    logic [47:0] res_exp_q[$];    // {score, x, y}

    logic [31:0] score_tab[NWIN];
    int          win_delay  = 0;
    bit          chk_consec = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- window buffer model ----------------
    initial begin
        int wait_cnt;
        win_valid = 1'b0;
        score_in  = '0;
        wait_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (win_valid) begin
                win_valid = 1'b0;
                wait_cnt  = 0;
            end else if (win_req) begin
                if (wait_cnt >= win_delay) begin
                    win_valid = 1'b1;
                    score_in  = score_tab[int'(win_y) * SW + int'(win_x)];
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int          load_run;
        logic        prev_req;
        logic        prev_wload;
        logic [15:0] prev_xy;
        logic [37:0] de;
        logic [15:0] we;
        logic [47:0] re;
        load_run   = 0;
        prev_req   = 1'b0;
        prev_wload = 1'b0;
        prev_xy    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                load_run = 0;
                prev_req = 1'b0;
                continue;
            end
            if (grid_desc_load) begin
                check("desc_load_needs_valid", desc_valid, 1);
                if (desc_exp_q.size() == 0) begin
                    check("desc_load_unexpected", 1, 0);
                end else begin
                    de = desc_exp_q.pop_front();
                    check("desc_slot_data", {grid_desc_row, grid_desc_col, grid_desc_data}, de);
                end
                load_run++;
            end else begin
                if (chk_consec && load_run > 0) begin
                    check("desc_consecutive_run", load_run, 64);
                    chk_consec = 0;
                end
                load_run = 0;
            end
            if (grid_win_load) begin
                check("win_load_needs_handshake", {win_req, win_valid}, 2'b11);
                if (win_exp_q.size() == 0) begin
                    check("win_load_unexpected", 1, 0);
                end else begin
                    we = win_exp_q.pop_front();
                    check("win_position", {win_x, win_y}, we);
                end
            end
            if (win_req && prev_req && !prev_wload)
                check("win_xy_stable", {win_x, win_y}, prev_xy);
            if (!busy)
                check("idle_no_strobes", {grid_desc_load, grid_win_load, done}, 3'b000);
            if (done) begin
                if (res_exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    re = res_exp_q.pop_front();
                    check("best_result", {best_score, best_x, best_y}, re);
                end
            end
            prev_req   = win_req;
            prev_wload = grid_win_load;
            prev_xy    = {win_x, win_y};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_windows();
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                win_exp_q.push_back({8'(x), 8'(y)});
    endtask

    task automatic send_descs(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            logic [5:0] idx;
            logic       rdy;
            int         guard;
            idx        = 6'(i);
            desc_data  = {8'(i), ~8'(i), 8'(i + 1), 8'hA5};
            desc_valid = 1'b1;
            desc_exp_q.push_back({idx[5:2], idx[1:0], desc_data});
            guard = 0;
            forever begin
                rdy = desc_ready;
                @(posedge clk);
                #1;
                if (rdy) break;
                guard++;
                if (guard > 50) begin
                    check("desc_accept_timeout", 0, 1);
                    desc_valid = 1'b0;
                    return;
                end
            end
            if (toggle) begin
                desc_valid = 1'b0;
                desc_data  = '0;
                @(posedge clk);
                #1;
            end
        end
        desc_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        bit got;
        got = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) check(name, 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n_done;
        bit hit;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        desc_valid = 1'b0;
        desc_data  = '0;
        for (int i = 0; i < NWIN; i++) score_tab[i] = 32'hFFFF_FFFB;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-descriptor after 10 words.
        do_start();
        send_descs(10, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_strobes", {desc_ready, grid_desc_load, win_req, grid_win_load}, 4'b0000);
        check("rst_desc_slot", {grid_desc_row, grid_desc_col, grid_desc_data}, 38'd0);
        check("rst_win_xy", {win_x, win_y}, 16'd0);
        check("rst_best", {best_score, best_x, best_y}, {32'h8000_0000, 16'd0});
        check("rst_state", dbg_state, ST_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_desc_queue_drained", desc_exp_q.size(), 0);

        // Full search: -5 everywhere, 7 at (2,1) and a tying 7 at (3,3).
        for (int i = 0; i < NWIN; i++) score_tab[i] = 32'hFFFF_FFFB;
        score_tab[1 * SW + 2] = 32'd7;
        score_tab[3 * SW + 3] = 32'd7;
        push_windows();
        res_exp_q.push_back({32'd7, 8'd2, 8'd1});
        chk_consec = 1;
        do_start();
        send_descs(64, 0);
        @(negedge clk);
        check("first_win_req", {win_req, win_x, win_y}, {1'b1, 16'd0});
        wait_done(1000, "search_tie_done_timeout");
        @(negedge clk);
        check("after_done_idle", {busy, done}, 2'b00);
        check("tie_queues_empty", {16'(win_exp_q.size()), 16'(res_exp_q.size())}, 32'd0);

        // All scores at the minimum: the first window must still be taken.
        for (int i = 0; i < NWIN; i++) score_tab[i] = 32'h8000_0000;
        push_windows();
        res_exp_q.push_back({32'h8000_0000, 8'd0, 8'd0});
        do_start();
        send_descs(64, 0);
        wait_done(1000, "search_min_done_timeout");

        // Abort during SETTLE of window (1,0).
        for (int i = 0; i < NWIN; i++) score_tab[i] = 32'hFFFF_FFFB;
        push_windows();
        do_start();
        send_descs(64, 0);
        hit = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (grid_win_load && win_x == 8'd1 && win_y == 8'd0) begin
                hit = 1;
                break;
            end
        end
        check("abort_reached_window_1_0", hit, 1);
        @(posedge clk);
        #1;
        check("abort_in_settle", dbg_state, ST_SETTLE);
        abort = 1'b1;
        @(negedge clk);
        check("abort_cycle_strobes", {grid_desc_load, grid_win_load, done}, 3'b000);
        @(posedge clk);
        #1;
        abort = 1'b0;
        win_exp_q.delete();
        @(negedge clk);
        check("abort_idle", {busy, dbg_state}, {1'b0, ST_IDLE});
        check("abort_best_reset", {best_score, best_x, best_y}, {32'h8000_0000, 16'd0});
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // start and abort together in IDLE: stay idle.
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", {busy, dbg_state}, {1'b0, ST_IDLE});

        // Restart from word 0 with toggled desc_valid and delayed win_valid.
        for (int i = 0; i < NWIN; i++) score_tab[i] = 32'(i - 10);
        score_tab[2 * SW + 1] = 32'd100;
        score_tab[3 * SW + 3] = 32'd100;
        win_delay = 3;
        push_windows();
        res_exp_q.push_back({32'd100, 8'd1, 8'd2});
        do_start();
        send_descs(64, 1);
        wait_done(2000, "search_stall_done_timeout");
        @(negedge clk);
        check("final_queues_empty",
              {16'(desc_exp_q.size()), 16'(win_exp_q.size()), 16'(res_exp_q.size())}, 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
